decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Registered RV32I(+M) decode stage between fetch and execute. Accepts {pc, instr} via valid/ready,
//  decodes opcode/funct/regs/immediate/control, and presents the result one cycle later.
//  Two-entry skid buffer gives full throughput under back-pressure. Supports flush and illegal-instruction causes.
// PARAMETERS
//  PC_W       32  width of pc_in/pc_out
//  ENABLE_M    1  1: decode OP funct7=0000001 as MUL/DIV; 0: treat it as illegal
//  FENCE_NOP   0  1: FENCE/FENCE.I retire as NOP (no write, no exception); 0: illegal
// PORTS
//  clk              in   1     clock, rising edge
//  rst_n            in   1     async active-low reset
//  flush            in   1     drop all held entries this cycle
//  in_valid         in   1     fetch offers {pc_in,instr}
//  in_ready         out  1     stage can accept
//  pc_in            in   PC_W  instruction address
//  instr            in   32    raw instruction word
//  out_valid        out  1     decoded entry valid
//  out_ready        in   1     execute accepts entry
//  pc_out           out  PC_W  pc of the presented entry
//  opcode           out  7     instr[6:0]
//  funct3           out  3     instr[14:12]
//  funct7           out  7     instr[31:25]
//  rd, rs1, rs2     out  5 ea  instr[11:7], [19:15], [24:20]
//  imm              out  32    sign-extended U/J/I/B/S immediate; 0 for R-type/illegal
//  reg_write_enable out  1     writes rd (forced 0 when rd==0)
//  mem_write_enable out  1     store
//  mem_read_enable  out  1     load
//  dst_data_source  out  2     0 Memory, 1 Flow Control, 2 ALU, 3 None
//  alu_src_imm      out  1     ALU operand B is imm (OP-IMM, LOAD, STORE)
//  is_muldiv        out  1     M-extension op
//  exception        out  1     illegal instruction
//  exc_cause        out  4     2 when exception, else 0
// BEHAVIOUR
//  Reset (async, rst_n=0): out_valid=0, in_ready=1, skid empty, all decoded outputs and pc_out = 0.
//  Decode (combinational on input, then registered); all outputs registered:
//   LUI/AUIPC U, JAL J, JALR I, BRANCH B -> src 1; LOAD I -> src 0, mem_read; STORE S -> src 3, mem_write;
//   OP-IMM I -> src 2; OP R -> src 2; reg_write 1 except BRANCH/STORE.
//  Illegal when: unknown opcode; instr[1:0]!=2'b11; JALR funct3!=0; BRANCH funct3 in {2,3};
//   LOAD funct3 in {3,6,7}; STORE funct3>2; SLLI funct7!=0; SRLI/SRAI funct7 not 0/0x20;
//   OP funct7 not 0x00/0x20 (0x20 only for funct3 0/5), or 0x01 when ENABLE_M=0; FENCE when FENCE_NOP=0.
//   Illegal => exception=1, exc_cause=2, reg/mem write/read 0, src 3, imm 0.
//  Latency: 1 cycle input-accept to out_valid. Throughput 1/cycle while out_ready=1.
//  States: EMPTY (out_valid=0), ONE (out reg valid), TWO (out reg + skid valid).
//   Accept = in_valid & in_ready; pop = out_valid & out_ready.
//   EMPTY: accept -> ONE.  ONE: accept&!pop -> TWO (new entry to skid); accept&pop -> ONE (new to out);
//   !accept&pop -> EMPTY.  TWO: pop -> ONE (skid moves to out); no accept possible.
//   in_ready = (state!=TWO), registered. Order strictly FIFO.
//  Handshake: out_* stable while out_valid & !out_ready. in_valid/instr may change only after accept.
//  flush=1: next state EMPTY, out_valid=0, in_ready=1; same-cycle input is discarded; flush wins over accept.
//  Reset mid-transfer discards all entries; no partial output.
// TESTING
//  1 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, imm=5, src=2, rwe=1, alu_src_imm=1
//  2 0x00112223 (sw x1,4(x2)) -> imm=4, rs1=2, rs2=1, mem_write_enable=1, rwe=0, src=3
//  3 0x022081B3 (mul x3,x1,x2): ENABLE_M=1 -> is_muldiv=1, rwe=1; ENABLE_M=0 -> exception=1, cause=2, rwe=0
//  4 addi x0,x0,0 (0x00000013) -> rwe=0, exception=0; 0x0000000F with FENCE_NOP=0 -> cause=2, =1 -> no exception
//  5 out_ready=0, three back-to-back instrs -> in_ready=0 after 2nd accept; release -> outputs in order, 1/cycle
//  6 flush in state TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1; rst_n low mid-stream -> all outputs 0

Source files
------------

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : Registered RV32I(+M) decode stage between fetch and execute.
//                Accepts {pc_in, instr} on a valid/ready handshake, decodes
//                opcode, register fields, immediate and control, and presents
//                the result one cycle later. A two-entry buffer (output
//                register + skid register) keeps one transfer per cycle going
//                under back-pressure while in_ready stays a pure register.
//
//  Ports
//    clk, rst_n            clock (rising edge), async active-low reset
//    flush                 drop every held entry; same-cycle input discarded
//    in_valid / in_ready   upstream handshake
//    pc_in, instr          instruction address and raw 32-bit word
//    out_valid / out_ready downstream handshake
//    pc_out .. exc_cause   decoded fields of the presented entry
//
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int PC_W      = 32,
    parameter int ENABLE_M  = 1,
    parameter int FENCE_NOP = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] pc_in,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] pc_out,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [31:0]     imm,
    output logic            reg_write_enable,
    output logic            mem_write_enable,
    output logic            mem_read_enable,
    output logic [1:0]      dst_data_source,
    output logic            alu_src_imm,
    output logic            is_muldiv,
    output logic            exception,
    output logic [3:0]      exc_cause
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] c_SRC_MEM  = 2'd0;
    localparam logic [1:0] c_SRC_FLOW = 2'd1;
    localparam logic [1:0] c_SRC_ALU  = 2'd2;
    localparam logic [1:0] c_SRC_NONE = 2'd3;

    localparam logic [3:0] c_CAUSE_ILLEGAL = 4'd2;

    // One complete decoded entry, as held in the output and skid registers.
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            reg_write_enable;
        logic            mem_write_enable;
        logic            mem_read_enable;
        logic [1:0]      dst_data_source;
        logic            alu_src_imm;
        logic            is_muldiv;
        logic            exception;
        logic [3:0]      exc_cause;
    } dec_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,   // nothing presented
        ST_ONE   = 2'd1,   // output register valid
        ST_TWO   = 2'd2    // output register and skid register valid
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_out_valid;
    logic        r_in_ready;
    dec_t        r_out;
    dec_t        r_skid;
    dec_t        w_dec;

    logic        w_accept;
    logic        w_pop;
    logic        w_load_out_in;
    logic        w_load_out_skid;
    logic        w_load_skid;
    logic        w_illegal;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;

    assign w_opc = instr[6:0];
    assign w_f3  = instr[14:12];
    assign w_f7  = instr[31:25];

    assign w_imm_i = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign w_imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign w_imm_u = {instr[31:12], 12'b0};
    assign w_imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    always_comb begin
        w_dec           = '0;
        w_illegal       = 1'b0;
        w_dec.pc        = pc_in;
        w_dec.opcode    = w_opc;
        w_dec.funct3    = w_f3;
        w_dec.funct7    = w_f7;
        w_dec.rd        = instr[11:7];
        w_dec.rs1       = instr[19:15];
        w_dec.rs2       = instr[24:20];
        w_dec.dst_data_source = c_SRC_NONE;

        case (w_opc)
            c_OPC_LUI, c_OPC_AUIPC: begin
                w_dec.imm              = w_imm_u;
                w_dec.dst_data_source  = c_SRC_FLOW;
                w_dec.reg_write_enable = 1'b1;
            end
            c_OPC_JAL: begin
                w_dec.imm              = w_imm_j;
                w_dec.dst_data_source  = c_SRC_FLOW;
                w_dec.reg_write_enable = 1'b1;
            end
            c_OPC_JALR: begin
                w_dec.imm              = w_imm_i;
                w_dec.dst_data_source  = c_SRC_FLOW;
                w_dec.reg_write_enable = 1'b1;
                if (w_f3 != 3'd0) w_illegal = 1'b1;
            end
            c_OPC_BRANCH: begin
                w_dec.imm             = w_imm_b;
                w_dec.dst_data_source = c_SRC_FLOW;
                if (w_f3 == 3'd2 || w_f3 == 3'd3) w_illegal = 1'b1;
            end
            c_OPC_LOAD: begin
                w_dec.imm              = w_imm_i;
                w_dec.dst_data_source  = c_SRC_MEM;
                w_dec.mem_read_enable  = 1'b1;
                w_dec.reg_write_enable = 1'b1;
                w_dec.alu_src_imm      = 1'b1;
                if (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7) w_illegal = 1'b1;
            end
            c_OPC_STORE: begin
                w_dec.imm              = w_imm_s;
                w_dec.dst_data_source  = c_SRC_NONE;
                w_dec.mem_write_enable = 1'b1;
                w_dec.alu_src_imm      = 1'b1;
                if (w_f3 > 3'd2) w_illegal = 1'b1;
            end
            c_OPC_OPIMM: begin
                w_dec.imm              = w_imm_i;
                w_dec.dst_data_source  = c_SRC_ALU;
                w_dec.reg_write_enable = 1'b1;
                w_dec.alu_src_imm      = 1'b1;
                // Shift-immediates reuse imm[11:5] as funct7; only the
                // encodings for SLLI, SRLI and SRAI are defined.
                case (w_f3)
                    3'd1:    if (w_f7 != 7'h00) w_illegal = 1'b1;
                    3'd5:    if (w_f7 != 7'h00 && w_f7 != 7'h20) w_illegal = 1'b1;
                    default: ;
                endcase
            end
            c_OPC_OP: begin
                w_dec.dst_data_source  = c_SRC_ALU;
                w_dec.reg_write_enable = 1'b1;
                if (w_f7 == 7'h00) begin
                    w_illegal = 1'b0;
                end else if (w_f7 == 7'h20) begin
                    // 0x20 only selects SUB and SRA.
                    if (w_f3 != 3'd0 && w_f3 != 3'd5) w_illegal = 1'b1;
                end else if (w_f7 == 7'h01) begin
                    if (ENABLE_M != 0) w_dec.is_muldiv = 1'b1;
                    else               w_illegal       = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_OPC_FENCE: begin
                // Retired as a NOP when allowed: no write, no memory access.
                if (FENCE_NOP == 0) w_illegal = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase

        if (instr[1:0] != 2'b11) w_illegal = 1'b1;

        if (w_illegal) begin
            w_dec.imm              = 32'd0;
            w_dec.reg_write_enable = 1'b0;
            w_dec.mem_write_enable = 1'b0;
            w_dec.mem_read_enable  = 1'b0;
            w_dec.dst_data_source  = c_SRC_NONE;
            w_dec.alu_src_imm      = 1'b0;
            w_dec.is_muldiv        = 1'b0;
            w_dec.exception        = 1'b1;
            w_dec.exc_cause        = c_CAUSE_ILLEGAL;
        end else if (instr[11:7] == 5'd0) begin
            // x0 is hard-wired; never request a write to it.
            w_dec.reg_write_enable = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Buffer control FSM
    // ------------------------------------------------------------------
    assign w_accept = in_valid & r_in_ready;
    assign w_pop    = r_out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            // Both handshake outputs are registered copies of the next state,
            // so neither depends combinationally on out_ready or in_valid.
            r_out_valid <= (w_state_nxt != ST_EMPTY);
            r_in_ready  <= (w_state_nxt != ST_TWO);
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;

        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt   = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_pop) begin
                    w_load_out_in = 1'b1;
                end else if (w_accept) begin
                    // Output is stalled; park the new entry behind it.
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt     = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase

        // Flush overrides everything, including a same-cycle accept.
        if (flush) begin
            w_state_nxt     = ST_EMPTY;
            w_load_out_in   = 1'b0;
            w_load_out_skid = 1'b0;
            w_load_skid     = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out  <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_out_in)        r_out <= w_dec;
            else if (w_load_out_skid) r_out <= r_skid;
            if (w_load_skid)          r_skid <= w_dec;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready         = r_in_ready;
    assign out_valid        = r_out_valid;
    assign pc_out           = r_out.pc;
    assign opcode           = r_out.opcode;
    assign funct3           = r_out.funct3;
    assign funct7           = r_out.funct7;
    assign rd               = r_out.rd;
    assign rs1              = r_out.rs1;
    assign rs2              = r_out.rs2;
    assign imm              = r_out.imm;
    assign reg_write_enable = r_out.reg_write_enable;
    assign mem_write_enable = r_out.mem_write_enable;
    assign mem_read_enable  = r_out.mem_read_enable;
    assign dst_data_source  = r_out.dst_data_source;
    assign alu_src_imm      = r_out.alu_src_imm;
    assign is_muldiv        = r_out.is_muldiv;
    assign exception        = r_out.exception;
    assign exc_cause        = r_out.exc_cause;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage
//  Description : Directed self-checking bench for decode_stage. A second
//                instance (ENABLE_M=0, FENCE_NOP=1) shares the stimulus so the
//                parameter-dependent decodes are checked side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pc_in;
    logic [31:0] instr;

    logic        in_ready, out_valid;
    logic [31:0] pc_out, imm;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic        reg_write_enable, mem_write_enable, mem_read_enable;
    logic [1:0]  dst_data_source;
    logic        alu_src_imm, is_muldiv, exception;
    logic [3:0]  exc_cause;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_pc_out, a_imm;
    logic [6:0]  a_opcode, a_funct7;
    logic [2:0]  a_funct3;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic        a_rwe, a_mwe, a_mre;
    logic [1:0]  a_src;
    logic        a_alu_src_imm, a_is_muldiv, a_exception;
    logic [3:0]  a_exc_cause;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.PC_W(32), .ENABLE_M(1), .FENCE_NOP(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .pc_out(pc_out), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .reg_write_enable(reg_write_enable), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable), .dst_data_source(dst_data_source),
        .alu_src_imm(alu_src_imm), .is_muldiv(is_muldiv),
        .exception(exception), .exc_cause(exc_cause)
    );

    decode_stage #(.PC_W(32), .ENABLE_M(0), .FENCE_NOP(1)) dut_alt (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .pc_in(pc_in), .instr(instr),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .pc_out(a_pc_out), .opcode(a_opcode), .funct3(a_funct3), .funct7(a_funct7),
        .rd(a_rd), .rs1(a_rs1), .rs2(a_rs2), .imm(a_imm),
        .reg_write_enable(a_rwe), .mem_write_enable(a_mwe),
        .mem_read_enable(a_mre), .dst_data_source(a_src),
        .alu_src_imm(a_alu_src_imm), .is_muldiv(a_is_muldiv),
        .exception(a_exception), .exc_cause(a_exc_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one word for a single cycle; caller guarantees in_ready=1.
    task automatic issue(input logic [31:0] pc, input logic [31:0] word);
        in_valid = 1'b1;
        pc_in    = pc;
        instr    = word;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (pc_out !== 32'd0 || imm !== 32'd0 || rd !== 5'd0 || opcode !== 7'd0)
            begin n_fail++; $display("FAIL reset_fields: pc=%h imm=%h rd=%0d opc=%h want all 0", pc_out, imm, rd, opcode); end
        n_checks++; if (reg_write_enable !== 1'b0 || exception !== 1'b0 || dst_data_source !== 2'd0)
            begin n_fail++; $display("FAIL reset_ctrl: rwe=%b exc=%b src=%0d want 0", reg_write_enable, exception, dst_data_source); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        issue(32'h0000_0100, 32'h0050_0093);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b want 1", out_valid); end
        n_checks++; if (rd !== 5'd1) begin n_fail++; $display("FAIL addi_rd: got %0d want 1", rd); end
        n_checks++; if (imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h want 5", imm); end
        n_checks++; if (dst_data_source !== 2'd2) begin n_fail++; $display("FAIL addi_src: got %0d want 2", dst_data_source); end
        n_checks++; if (reg_write_enable !== 1'b1) begin n_fail++; $display("FAIL addi_rwe: got %b want 1", reg_write_enable); end
        n_checks++; if (alu_src_imm !== 1'b1) begin n_fail++; $display("FAIL addi_alu_src_imm: got %b want 1", alu_src_imm); end
        n_checks++; if (pc_out !== 32'h100) begin n_fail++; $display("FAIL addi_pc: got %h want 100", pc_out); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_store;
        issue(32'h0000_0104, 32'h0011_2223);
        n_checks++; if (imm !== 32'd4) begin n_fail++; $display("FAIL sw_imm: got %h want 4", imm); end
        n_checks++; if (rs1 !== 5'd2 || rs2 !== 5'd1) begin n_fail++; $display("FAIL sw_regs: rs1=%0d rs2=%0d want 2,1", rs1, rs2); end
        n_checks++; if (mem_write_enable !== 1'b1) begin n_fail++; $display("FAIL sw_mwe: got %b want 1", mem_write_enable); end
        n_checks++; if (reg_write_enable !== 1'b0) begin n_fail++; $display("FAIL sw_rwe: got %b want 0", reg_write_enable); end
        n_checks++; if (dst_data_source !== 2'd3) begin n_fail++; $display("FAIL sw_src: got %0d want 3", dst_data_source); end
        @(posedge clk); #1;
    endtask

    task automatic test_muldiv;
        issue(32'h0000_0108, 32'h0220_81B3);
        n_checks++; if (is_muldiv !== 1'b1 || reg_write_enable !== 1'b1 || exception !== 1'b0)
            begin n_fail++; $display("FAIL mul_m_on: muldiv=%b rwe=%b exc=%b want 1,1,0", is_muldiv, reg_write_enable, exception); end
        n_checks++; if (rd !== 5'd3) begin n_fail++; $display("FAIL mul_rd: got %0d want 3", rd); end
        n_checks++; if (a_exception !== 1'b1 || a_exc_cause !== 4'd2 || a_rwe !== 1'b0 || a_is_muldiv !== 1'b0)
            begin n_fail++; $display("FAIL mul_m_off: exc=%b cause=%0d rwe=%b muldiv=%b want 1,2,0,0", a_exception, a_exc_cause, a_rwe, a_is_muldiv); end
        @(posedge clk); #1;
    endtask

    task automatic test_nop_fence;
        issue(32'h0000_010C, 32'h0000_0013);
        n_checks++; if (reg_write_enable !== 1'b0 || exception !== 1'b0)
            begin n_fail++; $display("FAIL nop_x0: rwe=%b exc=%b want 0,0", reg_write_enable, exception); end
        @(posedge clk); #1;
        issue(32'h0000_0110, 32'h0000_000F);
        n_checks++; if (exception !== 1'b1 || exc_cause !== 4'd2 || dst_data_source !== 2'd3)
            begin n_fail++; $display("FAIL fence_illegal: exc=%b cause=%0d src=%0d want 1,2,3", exception, exc_cause, dst_data_source); end
        n_checks++; if (a_exception !== 1'b0 || a_exc_cause !== 4'd0 || a_rwe !== 1'b0 || a_mwe !== 1'b0)
            begin n_fail++; $display("FAIL fence_nop: exc=%b cause=%0d rwe=%b mwe=%b want 0,0,0,0", a_exception, a_exc_cause, a_rwe, a_mwe); end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] word;
        logic [31:0] imm;
        logic [1:0]  src;
        logic        rwe;
        logic        mre;
        logic        exc;
    } vec_t;

    task automatic test_decode_table;
        vec_t v[13];
        v[0]  = '{32'h1234_52B7, 32'h1234_5000, 2'd1, 1'b1, 1'b0, 1'b0}; // lui x5
        v[1]  = '{32'h0080_00EF, 32'h0000_0008, 2'd1, 1'b1, 1'b0, 1'b0}; // jal x1,8
        v[2]  = '{32'hFE00_0EE3, 32'hFFFF_FFFC, 2'd1, 1'b0, 1'b0, 1'b0}; // beq -4
        v[3]  = '{32'hFF81_2303, 32'hFFFF_FFF8, 2'd0, 1'b1, 1'b1, 1'b0}; // lw x6,-8(x2)
        v[4]  = '{32'h4030_D093, 32'h0000_0403, 2'd2, 1'b1, 1'b0, 1'b0}; // srai x1,x1,3
        v[5]  = '{32'h4030_9093, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // slli f7=0x20
        v[6]  = '{32'h0050_0090, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // low bits != 11
        v[7]  = '{32'h0000_10E7, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // jalr f3=1
        v[8]  = '{32'h0001_3083, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // load f3=3
        v[9]  = '{32'h4020_81B3, 32'h0000_0000, 2'd2, 1'b1, 1'b0, 1'b0}; // sub x3
        v[10] = '{32'h4020_91B3, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // f7=0x20 f3=1
        v[11] = '{32'h0000_007F, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // unknown opcode
        v[12] = '{32'h0011_3223, 32'h0000_0000, 2'd3, 1'b0, 1'b0, 1'b1}; // store f3=3
        for (int i = 0; i < 13; i++) begin
            issue(32'h200 + 32'(i * 4), v[i].word);
            n_checks++; if (imm !== v[i].imm) begin n_fail++; $display("FAIL tbl%0d_imm: got %h want %h", i, imm, v[i].imm); end
            n_checks++; if (dst_data_source !== v[i].src) begin n_fail++; $display("FAIL tbl%0d_src: got %0d want %0d", i, dst_data_source, v[i].src); end
            n_checks++; if (reg_write_enable !== v[i].rwe) begin n_fail++; $display("FAIL tbl%0d_rwe: got %b want %b", i, reg_write_enable, v[i].rwe); end
            n_checks++; if (mem_read_enable !== v[i].mre) begin n_fail++; $display("FAIL tbl%0d_mre: got %b want %b", i, mem_read_enable, v[i].mre); end
            n_checks++; if (exception !== v[i].exc || exc_cause !== (v[i].exc ? 4'd2 : 4'd0))
                begin n_fail++; $display("FAIL tbl%0d_exc: exc=%b cause=%0d want exc=%b", i, exception, exc_cause, v[i].exc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0;
        issue(32'h300, 32'h0010_0093);            // addi x1
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_one: got %b want 1", in_ready); end
        issue(32'h304, 32'h0020_0113);            // addi x2
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_two: got %b want 0", in_ready); end
        n_checks++; if (out_valid !== 1'b1 || rd !== 5'd1) begin n_fail++; $display("FAIL b2b_head: valid=%b rd=%0d want 1,1", out_valid, rd); end
        in_valid = 1'b1; pc_in = 32'h308; instr = 32'h0030_0193;   // addi x3 held
        @(posedge clk); #1;
        n_checks++; if (rd !== 5'd1 || pc_out !== 32'h300 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL b2b_stable: rd=%0d pc=%h rdy=%b want 1,300,0", rd, pc_out, in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b1 || rd !== 5'd2 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL b2b_second: valid=%b rd=%0d rdy=%b want 1,2,1", out_valid, rd, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || rd !== 5'd3 || pc_out !== 32'h308)
            begin n_fail++; $display("FAIL b2b_third: valid=%b rd=%0d pc=%h want 1,3,308", out_valid, rd, pc_out); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        issue(32'h400, 32'h0010_0093);
        issue(32'h404, 32'h0020_0113);
        in_valid = 1'b1; pc_in = 32'h408; instr = 32'h0030_0193;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL flush_two: valid=%b rdy=%b want 0,1", out_valid, in_ready); end
        out_ready = 1'b1;
        // Flush in EMPTY with a same-cycle offer: the offer must be dropped.
        in_valid = 1'b1; pc_in = 32'h40C; instr = 32'h0050_0093; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wins: got %b want 0", out_valid); end
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_ghost: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        issue(32'h500, 32'h0050_0093);
        issue(32'h504, 32'h0011_2223);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL rst_mid_hs: valid=%b rdy=%b want 0,1", out_valid, in_ready); end
        n_checks++; if (pc_out !== 32'd0 || imm !== 32'd0 || rd !== 5'd0 || reg_write_enable !== 1'b0 || alu_src_imm !== 1'b0)
            begin n_fail++; $display("FAIL rst_mid_fields: pc=%h imm=%h rd=%0d rwe=%b asi=%b want 0", pc_out, imm, rd, reg_write_enable, alu_src_imm); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_partial: got %b want 0", out_valid); end
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pc_in     = 32'd0;
        instr     = 32'd0;

        test_reset;
        test_addi;
        test_store;
        test_muldiv;
        test_nop_fence;
        test_decode_table;
        test_back_to_back;
        test_flush;
        test_reset_mid;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
